led_pattern_gen: RTL and testbench

Parametrised multi-channel LED driver, the successor to the single free-running counter blinker. Each of N_CH channels independently runs OFF, STATIC (PWM dimmed), BLINK or BREATHE, paced by a shared programmable prescaler. It sits between the board clock and the RGB/LED pins and is configured by a simple write strobe from a controller or from switch-decode logic.

---
 rtl/led_pkg.sv | 16 +
 rtl/led_pattern_gen_channel.sv | 94 +++++++++
 rtl/led_pattern_gen.sv | 67 ++++++
 tb/tb_led_pattern_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the multi-channel LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } breathe_e;

endpackage

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: mode/level registers, blink phase, breathe ramp FSM and PWM output flop.
module led_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr,
  input  logic [1:0]       mode_in,
  input  logic [PWM_W-1:0] level_in,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  mode_e            mode_q, mode_d;
  logic [PWM_W-1:0] level_q, level_d;
  logic             phase_q, phase_d;
  logic [PWM_W-1:0] ramp_q, ramp_d;
  breathe_e         st_q, st_d;
  logic [PWM_W-1:0] duty;
  logic             led_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_OFF;
      level_q <= '0;
      phase_q <= 1'b0;
      ramp_q  <= '0;
      st_q    <= ST_UP;
      led     <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      level_q <= level_d;
      phase_q <= phase_d;
      ramp_q  <= ramp_d;
      st_q    <= st_d;
      led     <= led_d;
    end
  end

  // A write takes priority over a coincident tick and restarts the pattern.
  always_comb begin
    mode_d  = mode_q;
    level_d = level_q;
    phase_d = phase_q;
    ramp_d  = ramp_q;
    st_d    = st_q;
    if (wr) begin
      mode_d  = mode_e'(mode_in);
      level_d = level_in;
      phase_d = 1'b0;
      ramp_d  = '0;
      st_d    = ST_UP;
    end else if (tick) begin
      if (mode_q == MODE_BLINK) begin
        phase_d = ~phase_q;
      end
      if (mode_q == MODE_BREATHE) begin
        unique case (st_q)
          ST_UP: begin
            if (ramp_q < level_q) begin
              ramp_d = ramp_q + PWM_W'(1);
            end else begin
              st_d = ST_DOWN;
              if (ramp_q != '0) ramp_d = ramp_q - PWM_W'(1);
            end
          end
          ST_DOWN: begin
            if (ramp_q != '0) begin
              ramp_d = ramp_q - PWM_W'(1);
            end else begin
              st_d = ST_UP;
              if (level_q != '0) ramp_d = ramp_q + PWM_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    duty = '0;
    unique case (mode_q)
      MODE_OFF:     duty = '0;
      MODE_STATIC:  duty = level_q;
      MODE_BLINK:   duty = phase_q ? level_q : '0;
      MODE_BREATHE: duty = ramp_q;
    endcase
    led_d = (pwm_cnt < duty);
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared prescaler tick and free-running PWM counter feeding N_CH channels.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned PWM_W   = 8,
  parameter int unsigned PRESC_W = 24
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [PRESC_W-1:0]                           presc_div,
  input  logic                                         cfg_wr,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   cfg_ch,
  input  logic [1:0]                                   cfg_mode,
  input  logic [PWM_W-1:0]                             cfg_level,
  output logic                                         tick,
  output logic [N_CH-1:0]                              led
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               tick_d;
  logic [PWM_W-1:0]   pwm_cnt_q;

  // No early reload: if presc_div drops below the count, it runs on and wraps.
  always_comb begin
    tick_d      = 1'b0;
    presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    if (presc_cnt_q == presc_div) begin
      tick_d      = 1'b1;
      presc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
      tick        <= 1'b0;
      pwm_cnt_q   <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      tick        <= tick_d;
      pwm_cnt_q   <= pwm_cnt_q + PWM_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Out-of-range channel indices match no instance, so such writes vanish.
    logic wr_sel;
    assign wr_sel = cfg_wr && (cfg_ch == CH_W'(i));

    led_channel #(
      .PWM_W (PWM_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .wr       (wr_sel),
      .mode_in  (cfg_mode),
      .level_in (cfg_level),
      .pwm_cnt  (pwm_cnt_q),
      .led      (led[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench: per-cycle reference model plus directed/table tests for led_pattern_gen.
module tb_led_pattern_gen;

  localparam int N_CH    = 3;
  localparam int PWM_W   = 4;
  localparam int PRESC_W = 8;
  localparam int PWM_P   = 1 << PWM_W;
  localparam int PRESC_P = 1 << PRESC_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PRESC_W-1:0] presc_div = 8'd3;
  logic               cfg_wr = 1'b0;
  logic [1:0]         cfg_ch = '0;
  logic [1:0]         cfg_mode = '0;
  logic [PWM_W-1:0]   cfg_level = '0;
  logic               tick;
  logic [N_CH-1:0]    led;

  led_pattern_gen #(
    .N_CH    (N_CH),
    .PWM_W   (PWM_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .presc_div (presc_div),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_level (cfg_level),
    .tick      (tick),
    .led       (led)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each channel's pattern is a function of ticks seen since its last write.
  int m_mode [N_CH];
  int m_level[N_CH];
  int m_k    [N_CH];
  int m_cnt, m_pwm;
  bit m_tick;
  int exp_led;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int duty(input int i);
    int p;
    case (m_mode[i])
      1: return m_level[i];
      2: return (m_k[i] % 2 == 1) ? m_level[i] : 0;
      3: begin
        if (m_level[i] == 0) return 0;
        p = m_k[i] % (2 * m_level[i]);
        return (p <= m_level[i]) ? p : 2 * m_level[i] - p;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_mode[i] = 0; m_level[i] = 0; m_k[i] = 0;
    end
    m_cnt = 0; m_pwm = 0; m_tick = 0; exp_led = 0;
  endtask

  task automatic model_step();
    int nl;
    if (rst) begin
      model_reset();
      return;
    end
    nl = 0;
    for (int i = 0; i < N_CH; i++)
      if (m_pwm < duty(i)) nl |= (1 << i);
    exp_led = nl;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_wr && int'(cfg_ch) == i) begin
        m_mode[i] = int'(cfg_mode); m_level[i] = int'(cfg_level); m_k[i] = 0;
      end else if (m_tick) begin
        m_k[i]++;
      end
    end
    if (m_cnt == int'(presc_div)) begin
      m_tick = 1; m_cnt = 0;
    end else begin
      m_tick = 0; m_cnt = (m_cnt + 1) % PRESC_P;
    end
    m_pwm = (m_pwm + 1) % PWM_P;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led", int'(led), exp_led);
    check("tick", int'(tick), int'(m_tick));
  endtask

  task automatic wr(input int ch, input int mode, input int level);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_level = PWM_W'(level);
    cyc();
    cfg_wr = 1'b0;
  endtask

  typedef struct {
    int mode;
    int level;
    int exp_on;
  } vec_t;

  vec_t vecs[6];
  int   on_cnt;
  bit   found;

  initial begin
    model_reset();
    vecs[0] = '{mode: 1, level: 4,  exp_on: 4};
    vecs[1] = '{mode: 1, level: 0,  exp_on: 0};
    vecs[2] = '{mode: 1, level: 15, exp_on: 15};
    vecs[3] = '{mode: 1, level: 8,  exp_on: 8};
    vecs[4] = '{mode: 0, level: 9,  exp_on: 0};
    vecs[5] = '{mode: 1, level: 1,  exp_on: 1};

    repeat (3) cyc();
    check("reset_led", int'(led), 0);
    check("reset_tick", int'(tick), 0);

    // Reset release with presc_div=3: tick on cycles 4, 8, 12.
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      check("tick_seq", int'(tick), (n % 4 == 0) ? 1 : 0);
      check("dark_after_reset", int'(led), 0);
    end

    // Count has just reloaded to 0, so div=0 ticks at once without a wrap.
    presc_div = 8'd0;
    wr(2, 3, 3);
    repeat (40) cyc();
    wr(2, 3, 0);
    on_cnt = 0;
    repeat (32) begin
      cyc();
      on_cnt += int'(led[2]);
    end
    check("breathe_level0_dark", on_cnt, 0);

    foreach (vecs[v]) begin
      wr(0, vecs[v].mode, vecs[v].level);
      cyc();
      on_cnt = 0;
      repeat (PWM_P) begin
        cyc();
        on_cnt += int'(led[0]);
      end
      check("static_duty", on_cnt, vecs[v].exp_on);
    end

    presc_div = 8'd9;
    wr(2, 0, 0);
    wr(1, 2, 15);
    repeat (60) cyc();

    // Write ch0 on a tick cycle while its blink phase is 1.
    wr(0, 2, 15);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (tick && (m_k[0] % 2 == 1)) found = 1;
      else cyc();
    end
    check("collision_found", int'(found), 1);
    wr(0, 2, 15);
    on_cnt = 0;
    repeat (9) begin
      cyc();
      on_cnt += int'(led[0]);
    end
    check("wr_tick_dark", on_cnt, 0);
    repeat (20) cyc();

    wr(3, 1, 15);
    repeat (30) cyc();

    for (int n = 0; n < 1500; n++) begin
      if (n % 250 == 0) presc_div = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) begin
        wr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
      end else begin
        cyc();
      end
    end

    // Async reset between edges mid-breathe.
    presc_div = 8'd0;
    repeat (300) cyc();
    wr(2, 3, 15);
    wr(1, 1, 15);
    repeat (12) cyc();
    #2 rst = 1'b1;
    #1;
    check("async_led", int'(led), 0);
    check("async_tick", int'(tick), 0);
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    on_cnt = 0;
    repeat (40) begin
      cyc();
      on_cnt += int'(led != '0);
    end
    check("all_off_after_reset", on_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
